// File: rtl/mem_access_unit_if.sv
// Word-wide data-memory bus between the MEM-stage access unit (master) and
// the data memory (slave): request/acknowledge handshake plus address and data.
interface mem_access_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS32 MEM-stage data-memory access unit: places store lanes, extracts and
// extends load lanes, stalls the pipeline across a req/ack memory handshake.
module mem_access_unit (
   input  logic               clk,
   input  logic               reset,
   input  logic               req,
   input  logic               we,
   input  logic [1:0]         size,
   input  logic               sign,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   output logic               stall,
   output logic               done,
   output logic [31:0]        rdata,
   output logic               adel,
   output logic               ades,
   mem_access_unit_if.master  mem
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]  off_q, off_d;
   logic [1:0]  size_q, size_d;
   logic        sign_q, sign_d;
   logic [31:0] rdata_q, rdata_d;

   logic        misaligned;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_ext;

   // Size 2'b11 falls into the word case.
   always_comb begin
      misaligned = 1'b0;
      be_calc    = 4'b1111;
      wdata_calc = wdata;
      case (size)
         2'b00: begin
            be_calc    = 4'b0001 << addr[1:0];
            wdata_calc = {4{wdata[7:0]}};
         end
         2'b01: begin
            misaligned = addr[0];
            be_calc    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{wdata[15:0]}};
         end
         default: misaligned = |addr[1:0];
      endcase
   end

   always_comb begin
      case (off_q)
         2'd0:    byte_lane = mem.mem_rdata[7:0];
         2'd1:    byte_lane = mem.mem_rdata[15:8];
         2'd2:    byte_lane = mem.mem_rdata[23:16];
         default: byte_lane = mem.mem_rdata[31:24];
      endcase
      half_lane = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
      case (size_q)
         2'b00:   load_ext = {{24{sign_q & byte_lane[7]}}, byte_lane};
         2'b01:   load_ext = {{16{sign_q & half_lane[15]}}, half_lane};
         default: load_ext = mem.mem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      off_d       = off_q;
      size_d      = size_q;
      sign_d      = sign_q;
      rdata_d     = rdata_q;
      stall       = 1'b0;
      done        = 1'b0;
      adel        = 1'b0;
      ades        = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (misaligned) begin
                  adel = ~we;
                  ades = we;
               end else begin
                  stall       = 1'b1;
                  mem_req_d   = 1'b1;
                  mem_we_d    = we;
                  mem_be_d    = be_calc;
                  mem_addr_d  = {addr[31:2], 2'b00};
                  mem_wdata_d = wdata_calc;
                  off_d       = addr[1:0];
                  size_d      = size;
                  sign_d      = sign;
                  state_d     = BUSY;
               end
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (mem.mem_ack) begin
               mem_req_d = 1'b0;
               if (!mem_we_q) begin
                  rdata_d = load_ext;
               end
               state_d = RESP;
            end
         end
         RESP: begin
            // The retiring instruction still holds req; it must not restart.
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= 4'b0000;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         off_q       <= 2'b00;
         size_q      <= 2'b00;
         sign_q      <= 1'b0;
         rdata_q     <= 32'h0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         off_q       <= off_d;
         size_q      <= size_d;
         sign_q      <= sign_d;
         rdata_q     <= rdata_d;
      end
   end

   assign rdata         = rdata_q;
   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_be    = mem_be_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;

endmodule
